// File: rtl/data_mem_responder.sv
// data_mem_responder: fixed-latency byte-addressable data memory with a
// BUSYWAIT handshake toward a pipelined CPU's memory-access stage.
`default_nettype none

module data_mem_responder #(
    parameter int LATENCY     = 4,
    parameter int DEPTH_WORDS = 256
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MEM_READ,
    input  logic        MEM_WRITE,
    input  logic [2:0]  FUNC3,
    input  logic [31:0] ADDRESS,
    input  logic [31:0] WRITE_DATA,
    output logic [31:0] READ_DATA,
    output logic        BUSYWAIT,
    output logic        ERR
);

    localparam int         ADDR_BITS = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT_LOAD  = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                 state;
    logic [3:0]             count;
    logic [ADDR_BITS+1:0]   cap_addr;
    logic [2:0]             cap_func3;
    logic [31:0]            cap_wdata;
    logic                   cap_write;

    logic [31:0]            mem [DEPTH_WORDS];

    logic                   request;
    logic                   bad_access;
    logic [ADDR_BITS-1:0]   word_idx;
    logic [31:0]            rd_word;
    logic [15:0]            half_sel;
    logic [7:0]             byte_sel;
    logic [31:0]            load_value;
    logic [3:0]             byte_en;
    logic [31:0]            lane_data;
    logic                   commit;
    logic                   unused_addr_bits;

    assign request          = MEM_READ | MEM_WRITE;
    assign unused_addr_bits = ^ADDRESS[31:ADDR_BITS+2];

    // Gated by RESET so a request held high through reset cannot stall the CPU.
    assign BUSYWAIT = RESET & (((state == IDLE) & request) | (state == ACCESS));

    assign word_idx = cap_addr[ADDR_BITS+1:2];
    assign rd_word  = mem[word_idx];
    assign half_sel = cap_addr[1] ? rd_word[31:16] : rd_word[15:0];
    assign byte_sel = cap_addr[0] ? half_sel[15:8] : half_sel[7:0];

    // Unsigned sizes exist only for loads, so BU/HU encodings on a store are rejected.
    always_comb begin
        bad_access = 1'b0;
        case (cap_func3)
            3'b000:  bad_access = 1'b0;
            3'b001:  bad_access = cap_addr[0];
            3'b010:  bad_access = |cap_addr[1:0];
            3'b100:  bad_access = cap_write;
            3'b101:  bad_access = cap_write | cap_addr[0];
            default: bad_access = 1'b1;
        endcase
    end

    always_comb begin
        load_value = 32'd0;
        case (cap_func3)
            3'b000:  load_value = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_value = {{16{half_sel[15]}}, half_sel};
            3'b010:  load_value = rd_word;
            3'b100:  load_value = {24'd0, byte_sel};
            3'b101:  load_value = {16'd0, half_sel};
            default: load_value = 32'd0;
        endcase
    end

    always_comb begin
        byte_en   = 4'b0000;
        lane_data = cap_wdata;
        case (cap_func3[1:0])
            2'b00: begin
                byte_en   = 4'b0001 << cap_addr[1:0];
                lane_data = {4{cap_wdata[7:0]}};
            end
            2'b01: begin
                byte_en   = cap_addr[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{cap_wdata[15:0]}};
            end
            2'b10: begin
                byte_en   = 4'b1111;
                lane_data = cap_wdata;
            end
            default: begin
                byte_en   = 4'b0000;
                lane_data = cap_wdata;
            end
        endcase
    end

    assign commit = (state == ACCESS) & (count == 4'd0) & request & cap_write & ~bad_access;

    // Storage has no reset: contents survive RESET.
    always_ff @(posedge CLK) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[word_idx][8*i +: 8] <= lane_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state     <= IDLE;
            count     <= 4'd0;
            READ_DATA <= 32'd0;
            ERR       <= 1'b0;
            cap_addr  <= '0;
            cap_func3 <= 3'd0;
            cap_wdata <= 32'd0;
            cap_write <= 1'b0;
        end else begin
            READ_DATA <= 32'd0;
            ERR       <= 1'b0;
            case (state)
                IDLE: begin
                    if (request) begin
                        state     <= ACCESS;
                        count     <= LAT_LOAD;
                        cap_addr  <= ADDRESS[ADDR_BITS+1:0];
                        cap_func3 <= FUNC3;
                        cap_wdata <= WRITE_DATA;
                        cap_write <= MEM_WRITE;
                    end
                end
                ACCESS: begin
                    if (!request) begin
                        state <= IDLE;
                        count <= 4'd0;
                    end else if (count == 4'd0) begin
                        state     <= DONE;
                        ERR       <= bad_access;
                        READ_DATA <= (cap_write | bad_access) ? 32'd0 : load_value;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    count <= 4'd0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed self-checking bench for data_mem_responder
// (LATENCY=4, DEPTH_WORDS=256).
`default_nettype none

module tb_data_mem_responder;

    logic        CLK;
    logic        RESET;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [2:0]  FUNC3;
    logic [31:0] ADDRESS;
    logic [31:0] WRITE_DATA;
    logic [31:0] READ_DATA;
    logic        BUSYWAIT;
    logic        ERR;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    data_mem_responder #(
        .LATENCY     (4),
        .DEPTH_WORDS (256)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .MEM_READ   (MEM_READ),
        .MEM_WRITE  (MEM_WRITE),
        .FUNC3      (FUNC3),
        .ADDRESS    (ADDRESS),
        .WRITE_DATA (WRITE_DATA),
        .READ_DATA  (READ_DATA),
        .BUSYWAIT   (BUSYWAIT),
        .ERR        (ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issues one request at a negedge, counts BUSYWAIT-high cycles, and returns
    // READ_DATA/ERR sampled in the first cycle BUSYWAIT is low (the DONE cycle).
    task automatic do_req(input string tag, input logic rd, input logic wr,
                          input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd,
                          output logic [31:0] rdata, output logic err);
        int   busy_n;
        int   guard;
        logic leak;
        @(negedge CLK);
        MEM_READ   = rd;
        MEM_WRITE  = wr;
        FUNC3      = f3;
        ADDRESS    = addr;
        WRITE_DATA = wd;
        busy_n     = 0;
        guard      = 0;
        leak       = 1'b0;
        #1;
        while (BUSYWAIT && guard < 40) begin
            busy_n++;
            if (READ_DATA != 32'd0 || ERR != 1'b0) leak = 1'b1;
            @(negedge CLK);
            #1;
            guard++;
        end
        rdata = READ_DATA;
        err   = ERR;
        MEM_READ  = 1'b0;
        MEM_WRITE = 1'b0;
        check_eq({tag, "_busy_cycles"}, 32'(busy_n), 32'd5);
        check_eq({tag, "_quiet_while_busy"}, {31'd0, leak}, 32'd0);
    endtask

    logic [31:0] rdata;
    logic        err;

    initial begin
        RESET      = 1'b0;
        MEM_READ   = 1'b0;
        MEM_WRITE  = 1'b0;
        FUNC3      = 3'd0;
        ADDRESS    = 32'd0;
        WRITE_DATA = 32'd0;
        #1;
        check_eq("reset_busywait", {31'd0, BUSYWAIT}, 32'd0);
        check_eq("reset_read_data", READ_DATA, 32'd0);
        check_eq("reset_err", {31'd0, ERR}, 32'd0);
        repeat (3) @(negedge CLK);
        RESET = 1'b1;

        // Word store then load
        do_req("sw_beef", 1'b0, 1'b1, F_W, 32'h10, 32'hDEADBEEF, rdata, err);
        check_eq("sw_beef_err", {31'd0, err}, 32'd0);
        do_req("lw_beef", 1'b1, 1'b0, F_W, 32'h10, 32'h0, rdata, err);
        check_eq("lw_beef_data", rdata, 32'hDEADBEEF);
        check_eq("lw_beef_err", {31'd0, err}, 32'd0);

        // Byte store and sign/zero-extended byte loads
        do_req("sw_zero10", 1'b0, 1'b1, F_W, 32'h10, 32'h0, rdata, err);
        do_req("sb_80", 1'b0, 1'b1, F_B, 32'h13, 32'h00000080, rdata, err);
        do_req("lb_13", 1'b1, 1'b0, F_B, 32'h13, 32'h0, rdata, err);
        check_eq("lb_13_data", rdata, 32'hFFFFFF80);
        do_req("lbu_13", 1'b1, 1'b0, F_BU, 32'h13, 32'h0, rdata, err);
        check_eq("lbu_13_data", rdata, 32'h00000080);
        do_req("lw_10_after_sb", 1'b1, 1'b0, F_W, 32'h10, 32'h0, rdata, err);
        check_eq("lw_10_after_sb_data", rdata, 32'h80000000);

        // Halfword store to upper half, signed/unsigned halfword loads
        do_req("sw_zero14", 1'b0, 1'b1, F_W, 32'h14, 32'h0, rdata, err);
        do_req("sh_a5c3", 1'b0, 1'b1, F_H, 32'h16, 32'h7777A5C3, rdata, err);
        do_req("lh_16", 1'b1, 1'b0, F_H, 32'h16, 32'h0, rdata, err);
        check_eq("lh_16_data", rdata, 32'hFFFFA5C3);
        do_req("lhu_16", 1'b1, 1'b0, F_HU, 32'h16, 32'h0, rdata, err);
        check_eq("lhu_16_data", rdata, 32'h0000A5C3);
        do_req("lw_14", 1'b1, 1'b0, F_W, 32'h14, 32'h0, rdata, err);
        check_eq("lw_14_data", rdata, 32'hA5C30000);

        // Misaligned and illegal accesses
        do_req("lh_11", 1'b1, 1'b0, F_H, 32'h11, 32'h0, rdata, err);
        check_eq("lh_11_err", {31'd0, err}, 32'd1);
        check_eq("lh_11_data", rdata, 32'd0);
        do_req("sw_12", 1'b0, 1'b1, F_W, 32'h12, 32'hFFFFFFFF, rdata, err);
        check_eq("sw_12_err", {31'd0, err}, 32'd1);
        do_req("lw_10_after_bad_sw", 1'b1, 1'b0, F_W, 32'h10, 32'h0, rdata, err);
        check_eq("lw_10_after_bad_sw_data", rdata, 32'h80000000);
        check_eq("lw_10_after_bad_sw_err", {31'd0, err}, 32'd0);
        do_req("illegal_f3", 1'b1, 1'b0, 3'b011, 32'h10, 32'h0, rdata, err);
        check_eq("illegal_f3_err", {31'd0, err}, 32'd1);
        check_eq("illegal_f3_data", rdata, 32'd0);

        // Reset during ACCESS must block the pending write
        do_req("sw_1111", 1'b0, 1'b1, F_W, 32'h0, 32'h11111111, rdata, err);
        @(negedge CLK);
        MEM_WRITE  = 1'b1;
        FUNC3      = F_W;
        ADDRESS    = 32'h0;
        WRITE_DATA = 32'h12345678;
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        check_eq("midreset_busywait", {31'd0, BUSYWAIT}, 32'd0);
        check_eq("midreset_read_data", READ_DATA, 32'd0);
        MEM_WRITE = 1'b0;
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        do_req("lw_0_after_reset", 1'b1, 1'b0, F_W, 32'h0, 32'h0, rdata, err);
        check_eq("lw_0_after_reset_data", rdata, 32'h11111111);

        // Address wrap-around and read+write treated as write
        do_req("lw_400", 1'b1, 1'b0, F_W, 32'h400, 32'h0, rdata, err);
        check_eq("lw_400_data", rdata, 32'h11111111);
        do_req("rw_both", 1'b1, 1'b1, F_W, 32'h400, 32'hCAFEF00D, rdata, err);
        do_req("lw_0_after_both", 1'b1, 1'b0, F_W, 32'h0, 32'h0, rdata, err);
        check_eq("lw_0_after_both_data", rdata, 32'hCAFEF00D);

        // Aborted write: requests drop mid-ACCESS
        do_req("sw_zero20", 1'b0, 1'b1, F_W, 32'h20, 32'h0, rdata, err);
        @(negedge CLK);
        MEM_WRITE  = 1'b1;
        FUNC3      = F_W;
        ADDRESS    = 32'h20;
        WRITE_DATA = 32'h55555555;
        @(negedge CLK);
        @(negedge CLK);
        MEM_WRITE = 1'b0;
        @(negedge CLK);
        #1;
        check_eq("abort_busywait", {31'd0, BUSYWAIT}, 32'd0);
        do_req("lw_20_after_abort", 1'b1, 1'b0, F_W, 32'h20, 32'h0, rdata, err);
        check_eq("lw_20_after_abort_data", rdata, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 4, meaning the number of ACCESS-state cycles per request (legal 1..15).
REQ-002 SHALL have parameter DEPTH_WORDS, default 256, meaning storage size in 32-bit words (power of two).
REQ-003 SHALL have port CLK, input, 1, the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port RESET, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port MEM_READ, input, 1, load request from the CPU MA stage.
REQ-006 SHALL have port MEM_WRITE, input, 1, store request from the CPU MA stage.
REQ-007 SHALL have port FUNC3, input, 3, access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 SHALL have port ADDRESS, input, 32, byte address.
REQ-009 SHALL have port WRITE_DATA, input, 32, store data, right-aligned.
REQ-010 SHALL have port READ_DATA, output, 32, load result, extended to 32 bits.
REQ-011 SHALL have port BUSYWAIT, output, 1, stall to the CPU pipeline.
REQ-012 SHALL have port ERR, output, 1, misaligned or illegal-FUNC3 indication.

Function
REQ-013 SHALL implement states IDLE, ACCESS and DONE.
REQ-014 In IDLE with MEM_READ or MEM_WRITE high: BUSYWAIT SHALL be high combinationally in the same cycle; next state ACCESS with counter = LATENCY-1.
REQ-015 In ACCESS: BUSYWAIT high; counter decrements each cycle; at counter 0, the write is committed or the read is latched, and the next state is DONE.
REQ-016 In DONE: BUSYWAIT low; READ_DATA and ERR valid for exactly this cycle; next state IDLE unconditionally.
REQ-017 Timing: request raised in cycle 0 -> BUSYWAIT high in cycles 0..LATENCY, low in cycle LATENCY+1 (the DONE cycle).
REQ-018 The CPU holds ADDRESS, FUNC3 and WRITE_DATA stable while BUSYWAIT is high; the block captures them at the IDLE->ACCESS edge and uses the captured copy.
REQ-019 If MEM_READ and MEM_WRITE are both high, the request SHALL be treated as a write.
REQ-020 If both requests drop while in ACCESS, the access SHALL abort: return to IDLE, no memory write, BUSYWAIT low.
REQ-021 Word index SHALL be ADDRESS[log2(DEPTH_WORDS)+1:2]; higher address bits are ignored, so accesses wrap modulo storage size.
REQ-022 Stores SHALL update only the addressed bytes (SB: 1 lane by ADDRESS[1:0]; SH: 2 lanes by ADDRESS[1]; SW: all 4).
REQ-023 Loads SHALL select the addressed byte or half, then sign-extend for B/H and zero-extend for BU/HU.
REQ-024 Misaligned access (H/HU with ADDRESS[0]=1; W with ADDRESS[1:0]!=0) or illegal FUNC3 SHALL still take the full latency; in DONE, ERR=1, READ_DATA=0, and no byte is written.
REQ-025 READ_DATA SHALL be 0 in every cycle other than DONE of a successful read.
REQ-026 A new request present in IDLE the cycle after DONE SHALL start a new transaction with no extra idle cycle.

Reset
REQ-027 RESET low SHALL immediately force state IDLE, counter 0, BUSYWAIT 0, READ_DATA 0 and ERR 0, including mid-ACCESS; a pending write SHALL NOT commit.
REQ-028 Storage contents SHALL NOT be cleared by reset.
REQ-029 After RESET rises, the first request SHALL be serviced with the normal latency.

Verification
REQ-030 SW 0xDEADBEEF @0x10, then LW @0x10 -> each request has BUSYWAIT high for 5 cycles (LATENCY=4); the load returns READ_DATA=0xDEADBEEF in its DONE cycle, ERR=0.
REQ-031 SB 0x80 @0x13 over 0x00000000, then LB/LBU @0x13 -> 0xFFFFFF80 / 0x00000080; LW @0x10 -> 0x80000000.
REQ-032 LH @0x11 -> ERR=1 and READ_DATA=0 in DONE; SW @0x12 -> ERR=1 and the word at 0x10 is unchanged.
REQ-033 SW 0x12345678 @0x0, then RESET low during ACCESS cycle 2 -> BUSYWAIT drops asynchronously; a later LW @0x0 returns the previous contents.
REQ-034 LW @0x400 with DEPTH_WORDS=256 -> returns the word at 0x0 (wrap-around); MEM_READ and MEM_WRITE both high -> write performed.
